// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state types and address-step helper for the SRAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // FIXED holds the address; INCR and WRAP both step one 32-bit word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/sram_dp.sv
// Word-organised RAM: one byte-enabled write port, one combinational read port.
module sram_dp #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style 32-bit SRAM slave with independent read/write FSMs and programmable read latency.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Size is always treated as a full word, and the protection/cache/lock hints carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid};

  rd_state_t   r_state;
  logic [3:0]  r_id_q;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [1:0]  r_burst;
  logic [3:0]  r_cnt;
  logic        r_in_range;
  logic        r_issue;

  wr_state_t   w_state;
  logic [3:0]  w_id_q;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_beat;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        w_in_range;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign r_in_range = (r_addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign w_in_range = (w_addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign ram_we     = wready && wvalid && w_in_range;

  // r_addr always points at the next beat to issue, so the RAM read port can sit on it directly.
  assign r_issue = ((r_state == R_WAIT) && (r_cnt == 4'd0)) ||
                   ((r_state == R_BURST) && rready && !rlast);

  sram_dp #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_addr[MEM_AW+1:2]),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (r_addr[MEM_AW+1:2]),
    .rdata (ram_rdata)
  );

  // Read channel: accept AR, count down latency, then stream registered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rid     <= '0;
      rresp   <= '0;
      r_id_q  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_id_q  <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_burst <= arburst;
            r_beat  <= '0;
            r_cnt   <= 4'(READ_LAT - 1);
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) r_state <= R_BURST;
          else r_cnt <= r_cnt - 4'd1;
        end
        R_BURST: begin
          if (rready && rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase

      if (r_issue) begin
        rvalid <= 1'b1;
        rid    <= r_id_q;
        rdata  <= r_in_range ? ram_rdata : '0;
        rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        rlast  <= (r_beat == r_len);
        r_beat <= r_beat + 8'd1;
        r_addr <= next_addr(r_addr, r_burst);
      end
    end
  end

  // Write channel: accept AW, write beats until wlast, then hold the B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      w_id_q  <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_id_q  <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_burst <= awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_addr <= next_addr(w_addr, w_burst);
            w_beat <= w_beat + 8'd1;
            if (wlast) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id_q;
              bresp   <= (w_err || !w_in_range || (w_beat != w_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_err <= w_err || !w_in_range;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed vectors, corner sequences and random traffic vs a word-array model.
module tb_axi_sram_slave;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = '0;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0000_0000), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: 1024 words at byte addresses 0x000..0xFFF.
  logic [31:0] model [1024];
  logic [31:0] wbuf_d [256];
  logic [3:0]  wbuf_s [256];
  logic [31:0] rb_d [256];
  logic [1:0]  rb_r [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pre;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no DUT response, required one within the cycle bound", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return in_rng(a) ? model[a[11:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [7:0] len,
                                             input logic [1:0] burst, input int nb);
    bit err = (nb != int'(len) + 1);
    for (int i = 0; i < nb; i++) begin
      logic [31:0] ba = baddr(a, burst, i);
      if (!in_rng(ba)) err = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (wbuf_s[i][b]) model[ba[11:2]][8*b +: 8] = wbuf_d[i][8*b +: 8];
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  // Write burst of nb beats from wbuf; wlast rides on beat nb-1 regardless of len.
  task automatic axi_wr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                        input int nb, input logic [3:0] id, output logic [1:0] resp);
    int g = 0;
    wvalid = 1'b1; wdata = wbuf_d[0]; wstrb = wbuf_s[0]; wlast = (nb == 1);
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
    while (!awready && g < 600) begin tick; g++; end
    if (g >= 600) timeout("aw_handshake");
    chk("wready_before_aw", 32'(wready), 32'h0);
    tick;
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = wbuf_d[i]; wstrb = wbuf_s[i]; wlast = (i == nb - 1);
      g = 0;
      while (!wready && g < 50) begin tick; g++; end
      if (g >= 50) timeout("w_handshake");
      tick;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_wlast", 32'(bvalid), 32'h1);
    chk("bid", 32'(bid), 32'(id));
    resp = bresp;
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("awready_after_b", 32'(awready), 32'h1);
    chk("bvalid_cleared", 32'(bvalid), 32'h0);
  endtask

  // Read burst; mode 0 = rready held 1, 1 = toggle 1/0, 2 = random. cmp checks data against the model.
  task automatic axi_rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                        input logic [3:0] id, input int mode, input bit cmp);
    int g = 0;
    int lat = 0;
    int n = 0;
    int cyc = 0;
    bit hold = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    logic rr;
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
    while (!arready && g < 600) begin tick; g++; end
    if (g >= 600) timeout("ar_handshake");
    tick;
    arvalid = 1'b0;
    while (!rvalid && lat < 40) begin tick; lat++; end
    chk("read_latency", 32'(lat), 32'(LAT));
    while (n <= int'(len) && cyc < 3000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom % 2);
      rready = rr;
      if (hold) begin
        chk("rdata_hold", rdata, pd);
        chk("rlast_hold", 32'(rlast), 32'(pl));
        hold = 1'b0;
      end
      if (rvalid && rr) begin
        rb_d[n] = rdata;
        rb_r[n] = rresp;
        chk("rlast", 32'(rlast), 32'(n == int'(len)));
        chk("rid", 32'(rid), 32'(id));
        if (cmp) begin
          chk("rdata", rdata, exp_rd(baddr(a, burst, n)));
          chk("rresp", 32'(rresp), in_rng(baddr(a, burst, n)) ? 32'h0 : 32'h2);
        end
        n++;
      end else if (rvalid) begin
        hold = 1'b1; pd = rdata; pl = rlast;
      end
      tick;
      cyc++;
    end
    rready = 1'b0;
    if (cyc >= 3000) timeout("r_beats");
    chk("arready_after_last", 32'(arready), 32'h1);
    chk("rvalid_after_last", 32'(rvalid), 32'h0);
  endtask

  initial begin
    logic [1:0]  r;
    logic [1:0]  e;
    logic [31:0] old_w [4];
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  burst;
    int g;

    vt[0] = '{32'h20, 32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vt[1] = '{32'h24, 32'h11223344, 32'hAABBCCDD, 4'b1010, 32'hAA22CC44};
    vt[2] = '{32'h28, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 32'hFFFFFF00};
    vt[3] = '{32'h2C, 32'h00000000, 32'h12345678, 4'b1111, 32'h12345678};
    vt[4] = '{32'h30, 32'hDEADBEEF, 32'h01020304, 4'b0000, 32'hDEADBEEF};
    vt[5] = '{32'h36, 32'h55555555, 32'hA5A5A5A5, 4'b1100, 32'hA5A55555};

    repeat (3) tick;
    chk("rst_arready", 32'(arready), 32'h1);
    chk("rst_awready", 32'(awready), 32'h1);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_wready", 32'(wready), 32'h0);
    chk("rst_bvalid", 32'(bvalid), 32'h0);
    chk("rst_rlast", 32'(rlast), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rid", 32'(rid), 32'h0);
    chk("rst_rresp", 32'(rresp), 32'h0);
    chk("rst_bid", 32'(bid), 32'h0);
    chk("rst_bresp", 32'(bresp), 32'h0);
    rst = 1'b0;
    tick;

    // Fill the whole RAM with four 256-beat INCR bursts.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF; end
      axi_wr(32'(blk * 1024), 8'd255, 2'b01, 256, 4'(blk), r);
      e = model_write(32'(blk * 1024), 8'd255, 2'b01, 256);
      chk("fill_bresp", 32'(r), 32'(e));
    end
    axi_rd(32'h0, 8'd255, 2'b01, 4'h3, 0, 1'b1);

    // Single read after preloading a known word.
    wbuf_d[0] = 32'hCAFEF00D; wbuf_s[0] = 4'hF;
    axi_wr(32'h40, 8'd0, 2'b01, 1, 4'h1, r);
    e = model_write(32'h40, 8'd0, 2'b01, 1);
    chk("single_wr_bresp", 32'(r), 32'h0);
    axi_rd(32'h40, 8'd0, 2'b01, 4'h2, 0, 1'b1);
    chk("single_rdata", rb_d[0], 32'hCAFEF00D);
    chk("single_rresp", 32'(rb_r[0]), 32'h0);

    // INCR burst with rready toggling, then a FIXED burst.
    axi_rd(32'h100, 8'd7, 2'b01, 4'h4, 1, 1'b1);
    axi_rd(32'h104, 8'd3, 2'b00, 4'h4, 1, 1'b1);

    // Byte-strobe vectors.
    for (int i = 0; i < 6; i++) begin
      wbuf_d[0] = vt[i].pre; wbuf_s[0] = 4'hF;
      axi_wr(vt[i].addr, 8'd0, 2'b01, 1, 4'h7, r);
      e = model_write(vt[i].addr, 8'd0, 2'b01, 1);
      wbuf_d[0] = vt[i].wd; wbuf_s[0] = vt[i].strb;
      axi_wr(vt[i].addr, 8'd0, 2'b01, 1, 4'h8, r);
      e = model_write(vt[i].addr, 8'd0, 2'b01, 1);
      chk("strb_bresp", 32'(r), 32'h0);
      axi_rd(vt[i].addr, 8'd0, 2'b01, 4'h9, 0, 1'b1);
      chk("strb_rdata", rb_d[0], vt[i].exp);
    end

    // Out-of-range read and write (0x1000 aliases word 0 in the index bits).
    axi_rd(32'h1000, 8'd0, 2'b01, 4'hA, 0, 1'b1);
    chk("oor_rresp", 32'(rb_r[0]), 32'h2);
    chk("oor_rdata", rb_d[0], 32'h0);
    wbuf_d[0] = 32'h5A5A5A5A; wbuf_s[0] = 4'hF;
    axi_wr(32'h1000, 8'd0, 2'b01, 1, 4'hB, r);
    e = model_write(32'h1000, 8'd0, 2'b01, 1);
    chk("oor_bresp", 32'(r), 32'h2);
    axi_rd(32'h0, 8'd0, 2'b01, 4'hA, 0, 1'b1);

    // Early wlast: awlen 3, wlast on beat 1.
    for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'h3000_0000 + 32'(i); wbuf_s[i] = 4'hF; end
    axi_wr(32'h300, 8'd3, 2'b01, 4, 4'hC, r);
    e = model_write(32'h300, 8'd3, 2'b01, 4);
    chk("pre_early_bresp", 32'(r), 32'h0);
    wbuf_d[0] = 32'hE0E0E0E0; wbuf_d[1] = 32'hE1E1E1E1;
    axi_wr(32'h300, 8'd3, 2'b01, 2, 4'hD, r);
    e = model_write(32'h300, 8'd3, 2'b01, 2);
    chk("early_wlast_bresp", 32'(r), 32'h2);
    axi_rd(32'h300, 8'd3, 2'b01, 4'hD, 0, 1'b1);
    chk("early_word2_kept", rb_d[2], 32'h3000_0002);

    // Overlapping read and write on 0x200.
    for (int i = 0; i < 4; i++) begin
      old_w[i] = model[(32'h200 >> 2) + i];
      wbuf_d[i] = $urandom; wbuf_s[i] = 4'hF;
    end
    fork
      axi_rd(32'h200, 8'd3, 2'b01, 4'h5, 2, 1'b0);
      axi_wr(32'h200, 8'd3, 2'b01, 4, 4'h6, r);
    join
    e = model_write(32'h200, 8'd3, 2'b01, 4);
    chk("conc_bresp", 32'(r), 32'(e));
    for (int i = 0; i < 4; i++)
      chk("conc_rdata_old_or_new", 32'(rb_d[i] == old_w[i] || rb_d[i] == wbuf_d[i]), 32'h1);
    axi_rd(32'h200, 8'd3, 2'b01, 4'h5, 0, 1'b1);

    // Reset while beat 2 of a read burst is on the bus.
    arid = 4'h7; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    g = 0;
    while (!arready && g < 50) begin tick; g++; end
    tick;
    arvalid = 1'b0;
    rready = 1'b1;
    g = 0;
    begin
      int hs = 0;
      while (hs < 2 && g < 50) begin
        if (rvalid) hs++;
        tick;
        g++;
      end
    end
    if (g >= 50) timeout("rst_burst_beats");
    chk("rst_beat2_rvalid", 32'(rvalid), 32'h1);
    chk("rst_beat2_rdata", rdata, exp_rd(32'h108));
    rst = 1'b1;
    tick;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_arready", 32'(arready), 32'h1);
    chk("midrst_awready", 32'(awready), 32'h1);
    rst = 1'b0;
    rready = 1'b0;
    tick;
    axi_rd(32'h100, 8'd7, 2'b01, 4'h1, 0, 1'b1);

    // Random traffic against the model.
    for (int it = 0; it < 24; it++) begin
      a = (($urandom % 8) == 0) ? 32'h1000 + 32'(($urandom % 64) * 4) : 32'(($urandom % 1024) * 4);
      a[1:0] = 2'($urandom % 4);
      len = 8'($urandom % 4);
      burst = 2'($urandom % 3);
      for (int i = 0; i <= int'(len); i++) begin wbuf_d[i] = $urandom; wbuf_s[i] = 4'($urandom); end
      axi_wr(a, len, burst, int'(len) + 1, 4'($urandom), r);
      e = model_write(a, len, burst, int'(len) + 1);
      chk("rand_bresp", 32'(r), 32'(e));
      a = (($urandom % 8) == 0) ? 32'h2000 : 32'(($urandom % 1024) * 4);
      axi_rd(a, 8'($urandom % 6), 2'($urandom % 3), 4'($urandom), 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

endmodule
